sram_port_ctrl: RTL and testbench

- Initiator side of one 64x128 single-port SRAM macro port (`S011HD1P_X32Y2D128_BW`: active-low CEN/WEN, active-low per-bit BWEN, read data on Q one cycle after access).
- Converts a 64-bit CPU-side request stream (valid/ready, byte strobes) into macro pin activity and returns read data.
- Zero-fills the whole array after reset or on flush.
- One instance drives each `io_sramN_*` group of the SRAM wrapper.

---
 rtl/sram_port_ctrl.sv | 162 ++++++++++++++++
 tb/tb_sram_port_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_ctrl.sv
// Request-stream front end for one 64x128 single-port SRAM macro port: zero-fills
// the array after reset/flush, then maps 64-bit requests onto macro pins.
// Optional build macro SRAM_RDATA_REG_EN adds one register stage on the response.
`timescale 1ns/1ps
module sram_port_ctrl #(
  parameter int ROWS   = 64,
  parameter int ROW_AW = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ROW_AW:0]   req_addr,
  input  logic [63:0]       req_wdata,
  input  logic [7:0]        req_wstrb,
  output logic              resp_valid,
  output logic [63:0]       resp_rdata,
  output logic              init_done,
  output logic [ROW_AW-1:0] sram_addr,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [127:0]      sram_wmask,
  output logic [127:0]      sram_wdata,
  input  logic [127:0]      sram_rdata,
  output logic              dbg_state
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ROW_AW-1:0] cnt_q, cnt_d;
  logic              resp_pend_q, resp_pend_d;
  logic              rd_q, rd_d;
  logic              half_q, half_d;
  logic              fire;
  logic [63:0]       rdata_sel;

  // Handshake: a request transfers in the cycle where req_valid && req_ready are
  // both high; req_ready never depends on req_valid, and the response side has no
  // backpressure (exactly one resp_valid pulse per transfer, in order).
  assign fire      = req_valid && req_ready;
  assign dbg_state = state_q;
  assign init_done = (state_q == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ROW_AW'(ROWS - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_IDLE: begin
        if (flush) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Macro pins follow the handshake combinationally in the accepting cycle.
  always_comb begin
    req_ready  = 1'b0;
    sram_cen   = 1'b1;
    sram_wen   = 1'b1;
    sram_wmask = '1;
    sram_wdata = '0;
    sram_addr  = '0;
    case (state_q)
      ST_INIT: begin
        sram_cen   = 1'b0;
        sram_wen   = 1'b0;
        sram_wmask = '0;
        sram_addr  = cnt_q;
      end
      ST_IDLE: begin
        req_ready = !flush;
        if (fire) begin
          sram_addr = req_addr[ROW_AW:1];
          if (req_wen) begin
            sram_wen   = 1'b0;
            sram_cen   = (req_wstrb == 8'h00);
            sram_wdata = {req_wdata, req_wdata};
            for (int i = 0; i < 8; i++) begin
              if (req_addr[0]) sram_wmask[64 + 8*i +: 8] = {8{~req_wstrb[i]}};
              else             sram_wmask[8*i +: 8]      = {8{~req_wstrb[i]}};
            end
          end else begin
            sram_cen = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    resp_pend_d = fire;
    rd_d        = fire && !req_wen;
    half_d      = req_addr[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_pend_q <= 1'b0;
      rd_q        <= 1'b0;
      half_q      <= 1'b0;
    end else begin
      resp_pend_q <= resp_pend_d;
      rd_q        <= rd_d;
      half_q      <= half_d;
    end
  end

  // Write responses carry zero data; reads pick the half latched at accept time.
  assign rdata_sel = rd_q ? (half_q ? sram_rdata[127:64] : sram_rdata[63:0]) : 64'h0;

`ifdef SRAM_RDATA_REG_EN
  logic        resp_valid_q;
  logic [63:0] resp_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= resp_pend_q;
      resp_rdata_q <= rdata_sel;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
`else
  assign resp_valid = resp_pend_q;
  assign resp_rdata = rdata_sel;
`endif

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Bench for sram_port_ctrl: behavioural macro model, reference array and an
// expected-response queue tagged with the cycle each response is due.
`timescale 1ns/1ps
module tb_sram_port_ctrl;

`ifdef SRAM_RDATA_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         req_valid;
  logic         req_ready;
  logic         req_wen;
  logic [6:0]   req_addr;
  logic [63:0]  req_wdata;
  logic [7:0]   req_wstrb;
  logic         resp_valid;
  logic [63:0]  resp_rdata;
  logic         init_done;
  logic [5:0]   sram_addr;
  logic         sram_cen;
  logic         sram_wen;
  logic [127:0] sram_wmask;
  logic [127:0] sram_wdata;
  logic [127:0] sram_rdata;
  logic         dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [95:0]  exp_q[$];
  logic [127:0] exp_mem [64];
  logic [127:0] macro_mem [64];

  sram_port_ctrl #(.ROWS(64), .ROW_AW(6)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .init_done(init_done),
    .sram_addr(sram_addr), .sram_cen(sram_cen), .sram_wen(sram_wen),
    .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .dbg_state(dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Macro model: Q is valid the cycle after an access; writes are visible to Q.
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_wen) begin
        macro_mem[sram_addr] <= (macro_mem[sram_addr] & sram_wmask) | (sram_wdata & ~sram_wmask);
        sram_rdata <= (macro_mem[sram_addr] & sram_wmask) | (sram_wdata & ~sram_wmask);
      end else begin
        sram_rdata <= macro_mem[sram_addr];
      end
    end
  end

  // Driver tasks
  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Sample point: negedge; scoreboard pops any response observed this cycle.
  task automatic step();
    logic [95:0] e;
    @(negedge clk);
    if (exp_q.size() > 0 && int'(exp_q[0][95:64]) < cyc) begin
      checks++;
      errors++;
      $display("FAIL resp_missing cycle=%0d due=%0d resp_valid=%b", cyc, int'(exp_q[0][95:64]), resp_valid);
      void'(exp_q.pop_front());
    end
    if (resp_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected cycle=%0d rdata=%h", cyc, resp_rdata);
      end else begin
        e = exp_q.pop_front();
        if (int'(e[95:64]) != cyc || resp_rdata !== e[63:0]) begin
          errors++;
          $display("FAIL resp cycle=%0d due=%0d rdata=%h expected=%h", cyc, int'(e[95:64]), resp_rdata, e[63:0]);
        end
      end
    end
  endtask

  task automatic idle();
    req_valid = 1'b0;
    flush     = 1'b0;
    req_wen   = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
  endtask

  task automatic issue(input logic wen, input logic [6:0] addr, input logic [63:0] wdata,
                       input logic [7:0] wstrb);
    logic [127:0] exp_mask;
    logic [63:0]  exp_r;
    logic [5:0]   row;
    int           h;
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = wstrb;
    row = addr[6:1];
    h   = int'(addr[0]);
    step();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready addr=%h got=%b expected=1", addr, req_ready);
    end
    if (!wen) begin
      exp_r = (h == 1) ? exp_mem[row][127:64] : exp_mem[row][63:0];
      checks++;
      if (sram_cen !== 1'b0 || sram_wen !== 1'b1 || sram_wmask !== {128{1'b1}} || sram_addr !== row) begin
        errors++;
        $display("FAIL rd_pins addr=%h cen=%b wen=%b addr_pin=%h wmask=%h expected cen=0 wen=1 addr_pin=%h all-ones",
                 addr, sram_cen, sram_wen, sram_addr, sram_wmask, row);
      end
    end else begin
      exp_mask = {128{1'b1}};
      for (int i = 0; i < 8; i++) exp_mask[64*h + 8*i +: 8] = {8{~wstrb[i]}};
      checks++;
      if (sram_cen !== (wstrb == 8'h00) || sram_wen !== 1'b0 || sram_wmask !== exp_mask ||
          sram_wdata !== {wdata, wdata} || sram_addr !== row) begin
        errors++;
        $display("FAIL wr_pins addr=%h cen=%b wen=%b addr_pin=%h wmask=%h wdata=%h expected cen=%b wen=0 addr_pin=%h wmask=%h",
                 addr, sram_cen, sram_wen, sram_addr, sram_wmask, sram_wdata, (wstrb == 8'h00), row, exp_mask);
      end
      for (int i = 0; i < 8; i++)
        if (wstrb[i]) exp_mem[row][64*h + 8*i +: 8] = wdata[8*i +: 8];
      exp_r = 64'h0;
    end
    exp_q.push_back({32'(cyc + LAT), exp_r});
    advance();
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      advance();
    end
  endtask

  // Checks n zero-fill cycles starting at row 0; flush pulsed on cycle flush_at.
  task automatic fill_check(input int n, input int flush_at);
    for (int k = 0; k < n; k++) begin
      flush = (k == flush_at);
      step();
      checks++;
      if (sram_cen !== 1'b0 || sram_wen !== 1'b0 || sram_wmask !== 128'h0 || sram_wdata !== 128'h0 ||
          sram_addr !== 6'(k) || req_ready !== 1'b0 || init_done !== 1'b0) begin
        errors++;
        $display("FAIL fill k=%0d cen=%b wen=%b wmask=%h wdata=%h addr=%h ready=%b init_done=%b expected addr=%h zeros",
                 k, sram_cen, sram_wen, sram_wmask, sram_wdata, sram_addr, req_ready, init_done, 6'(k));
      end
      advance();
    end
    flush = 1'b0;
  endtask

  task automatic finish_fill();
    step();
    checks++;
    if (init_done !== 1'b1 || req_ready !== 1'b1 || dbg_state !== 1'b1 || sram_cen !== 1'b1) begin
      errors++;
      $display("FAIL fill_done init_done=%b ready=%b state=%b cen=%b expected 1 1 1 1",
               init_done, req_ready, dbg_state, sram_cen);
    end
    for (int r = 0; r < 64; r++) exp_mem[r] = '0;
    advance();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    exp_q.delete();
    idle();
    advance();
    advance();
    rst_n = 1'b1;
  endtask

  // Tests
  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    advance();
    step();
    checks++;
    if (req_ready !== 1'b0 || init_done !== 1'b0 || resp_valid !== 1'b0 || dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL reset_state ready=%b init_done=%b resp_valid=%b state=%b expected all 0",
               req_ready, init_done, resp_valid, dbg_state);
    end
    advance();
    rst_n = 1'b1;
    fill_check(64, 10);
    finish_fill();
    issue(1'b0, 7'h7F, 64'h0, 8'h00);
    idle();
    wait_cycles(LAT + 1);
  endtask

  task automatic test_full_write();
    issue(1'b1, 7'h05, 64'h1122334455667788, 8'hFF);
    issue(1'b0, 7'h05, 64'h0, 8'h00);
    issue(1'b0, 7'h04, 64'h0, 8'h00);
    idle();
    wait_cycles(LAT + 1);
  endtask

  task automatic test_partial_write();
    issue(1'b1, 7'h05, 64'hAAAAAAAABBBBBBBB, 8'h0F);
    idle();
    checks++;
    if (exp_mem[2][127:64] !== 64'h11223344BBBBBBBB) begin
      errors++;
      $display("FAIL partial_model got=%h expected=%h", exp_mem[2][127:64], 64'h11223344BBBBBBBB);
    end
    issue(1'b0, 7'h05, 64'h0, 8'h00);
    idle();
    wait_cycles(LAT + 1);
  endtask

  task automatic test_zero_strobe();
    issue(1'b1, 7'h05, 64'hDEADBEEFCAFEF00D, 8'h00);
    idle();
    issue(1'b0, 7'h05, 64'h0, 8'h00);
    idle();
    wait_cycles(LAT + 1);
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 7'h05, 64'h0, 8'h00);
    issue(1'b1, 7'h03, 64'h0F1E2D3C4B5A6978, 8'hFF);
    issue(1'b0, 7'h03, 64'h0, 8'h00);
    idle();
    wait_cycles(LAT + 1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      issue(1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), {$urandom, $urandom},
            8'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) begin
        idle();
        wait_cycles(1);
      end
    end
    idle();
    wait_cycles(LAT + 1);
  endtask

  task automatic test_flush();
    issue(1'b1, 7'h10, 64'h5555666677778888, 8'hFF);
    idle();
    wait_cycles(LAT + 1);
    req_valid = 1'b1;
    req_wen   = 1'b1;
    req_addr  = 7'h11;
    req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    req_wstrb = 8'hFF;
    flush     = 1'b1;
    step();
    checks++;
    if (req_ready !== 1'b0 || sram_cen !== 1'b1 || init_done !== 1'b1) begin
      errors++;
      $display("FAIL flush_cycle ready=%b cen=%b init_done=%b expected 0 1 1", req_ready, sram_cen, init_done);
    end
    advance();
    idle();
    fill_check(64, -1);
    finish_fill();
    issue(1'b0, 7'h05, 64'h0, 8'h00);
    issue(1'b0, 7'h03, 64'h0, 8'h00);
    issue(1'b0, 7'h10, 64'h0, 8'h00);
    idle();
    wait_cycles(LAT + 1);
  endtask

  task automatic test_reset_mid();
    issue(1'b1, 7'h20, 64'h0123456789ABCDEF, 8'hFF);
    issue(1'b0, 7'h20, 64'h0, 8'h00);
    idle();
    rst_n = 1'b0;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || dbg_state !== 1'b0 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_inflight resp_valid=%b state=%b init_done=%b expected 0 0 0",
               resp_valid, dbg_state, init_done);
    end
    apply_reset();
    fill_check(20, -1);
    apply_reset();
    fill_check(64, 5);
    finish_fill();
    issue(1'b0, 7'h20, 64'h0, 8'h00);
    idle();
    wait_cycles(LAT + 1);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_full_write();
    test_partial_write();
    test_zero_strobe();
    test_back_to_back();
    test_random();
    test_flush();
    test_reset_mid();
    wait_cycles(LAT + 2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
